// File: rtl/pwm_pkg.sv
// Shared types for the three-phase PWM scheduler: carrier width/type and leg FSM states.
package pwm_pkg;
    localparam int CARRIER_W    = 16;
    localparam int DT_W_DEFAULT = 8;

    typedef logic signed [CARRIER_W-1:0] carrier_t;

    typedef enum logic [2:0] {
        SAFE,
        HIGH,
        LOW,
        DT_H,
        DT_L
    } leg_state_t;
endpackage

// File: rtl/deadtime_leg.sv
// One inverter leg: turns a compare bit into a complementary gate pair with dead time.
// Latency: turn-off one edge after cmp changes, turn-on DEADTIME enabled edges later; enable low freezes it.
module deadtime_leg
    import pwm_pkg::*;
#(
    parameter int DEADTIME = 50,
    parameter int DT_W     = DT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cmp,
    input  logic fault_latched,
    output logic gate_h,
    output logic gate_l
);
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);

    leg_state_t      state;
    logic [DT_W-1:0] cnt;
    logic            fresh;

    // A dead time started from SAFE has no previously-on gate to return to, so it
    // always runs to completion and then follows cmp.
    always_ff @(posedge clk) begin
        if (reset || fault_latched) begin
            state  <= SAFE;
            cnt    <= '0;
            fresh  <= 1'b0;
            gate_h <= 1'b0;
            gate_l <= 1'b0;
        end else if (enable) begin
            unique case (state)
                SAFE: begin
                    state <= cmp ? DT_H : DT_L;
                    cnt   <= DT_LOAD;
                    fresh <= 1'b1;
                end
                HIGH: begin
                    if (!cmp) begin
                        state  <= DT_L;
                        cnt    <= DT_LOAD;
                        gate_h <= 1'b0;
                    end
                end
                LOW: begin
                    if (cmp) begin
                        state  <= DT_H;
                        cnt    <= DT_LOAD;
                        gate_l <= 1'b0;
                    end
                end
                DT_H, DT_L: begin
                    if (!fresh && state == DT_L && cmp) begin
                        state  <= HIGH;
                        gate_h <= 1'b1;
                    end else if (!fresh && state == DT_H && !cmp) begin
                        state  <= LOW;
                        gate_l <= 1'b1;
                    end else if (cnt == '0) begin
                        state  <= cmp ? HIGH : LOW;
                        gate_h <= cmp;
                        gate_l <= !cmp;
                        fresh  <= 1'b0;
                    end else begin
                        cnt <= cnt - DT_W'(1);
                    end
                end
                default: begin
                    state  <= SAFE;
                    gate_h <= 1'b0;
                    gate_l <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/pwm3_leg_scheduler.sv
// Three-phase PWM: triangle carrier, double-buffered modulation, signed compare, dead-time legs, fault latch.
// Latency: compare registered one edge after carrier; gates follow per deadtime_leg; no backpressure, enable freezes.
module pwm3_leg_scheduler
    import pwm_pkg::*;
#(
    parameter int CARRIER_MAX  = 1000,
    parameter int CARRIER_STEP = 1,
    parameter int DEADTIME     = 50,
    parameter int DT_W         = DT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] mod_a,
    input  logic signed [15:0] mod_b,
    input  logic signed [15:0] mod_c,
    input  logic               mod_valid,
    input  logic               fault,
    input  logic               fault_clr,
    output logic signed [15:0] carrier,
    output logic               sync_pulse,
    output logic               gate_ah,
    output logic               gate_al,
    output logic               gate_bh,
    output logic               gate_bl,
    output logic               gate_ch,
    output logic               gate_cl,
    output logic               fault_latched
);
    localparam carrier_t C_MAX  = carrier_t'(CARRIER_MAX);
    localparam carrier_t C_MIN  = carrier_t'(-CARRIER_MAX);
    localparam carrier_t C_STEP = carrier_t'(CARRIER_STEP);

    logic     dir_up;
    carrier_t carrier_nxt;
    logic     at_turn;
    carrier_t shadow_a, shadow_b, shadow_c;
    carrier_t active_a, active_b, active_c;
    logic     cmp_a, cmp_b, cmp_c;
    logic     fault_any;

    assign carrier_nxt = dir_up ? carrier + C_STEP : carrier - C_STEP;
    assign at_turn     = (carrier == C_MAX) || (carrier == C_MIN);
    // The raw fault input bypasses the latch so the legs drop on the same edge.
    assign fault_any   = fault | fault_latched;

    always_ff @(posedge clk) begin
        if (reset) begin
            carrier    <= C_MIN;
            dir_up     <= 1'b1;
            sync_pulse <= 1'b1;
            active_a   <= '0;
            active_b   <= '0;
            active_c   <= '0;
            cmp_a      <= 1'b0;
            cmp_b      <= 1'b0;
            cmp_c      <= 1'b0;
        end else if (enable) begin
            carrier    <= carrier_nxt;
            sync_pulse <= (carrier_nxt == C_MIN);
            if (dir_up && carrier_nxt == C_MAX) begin
                dir_up <= 1'b0;
            end else if (!dir_up && carrier_nxt == C_MIN) begin
                dir_up <= 1'b1;
            end
            if (at_turn) begin
                active_a <= shadow_a;
                active_b <= shadow_b;
                active_c <= shadow_c;
            end
            cmp_a <= (active_a > carrier);
            cmp_b <= (active_b > carrier);
            cmp_c <= (active_c > carrier);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_a <= '0;
            shadow_b <= '0;
            shadow_c <= '0;
        end else if (mod_valid) begin
            shadow_a <= mod_a;
            shadow_b <= mod_b;
            shadow_c <= mod_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else if (fault_clr) begin
            fault_latched <= 1'b0;
        end
    end

    deadtime_leg #(.DEADTIME(DEADTIME), .DT_W(DT_W)) u_leg_a (
        .clk(clk), .reset(reset), .enable(enable), .cmp(cmp_a),
        .fault_latched(fault_any), .gate_h(gate_ah), .gate_l(gate_al)
    );

    deadtime_leg #(.DEADTIME(DEADTIME), .DT_W(DT_W)) u_leg_b (
        .clk(clk), .reset(reset), .enable(enable), .cmp(cmp_b),
        .fault_latched(fault_any), .gate_h(gate_bh), .gate_l(gate_bl)
    );

    deadtime_leg #(.DEADTIME(DEADTIME), .DT_W(DT_W)) u_leg_c (
        .clk(clk), .reset(reset), .enable(enable), .cmp(cmp_c),
        .fault_latched(fault_any), .gate_h(gate_ch), .gate_l(gate_cl)
    );
endmodule

// File: tb/tb_pwm3_leg_scheduler.sv
// Bench for pwm3_leg_scheduler with CARRIER_MAX=8, STEP=1, DEADTIME=3.
module tb_pwm3_leg_scheduler;
    localparam int CMAX = 8;
    localparam int STEP = 1;
    localparam int DT   = 3;

    logic clk = 1'b0;
    logic reset, enable, mod_valid, fault, fault_clr;
    logic signed [15:0] mod_a, mod_b, mod_c;
    logic signed [15:0] carrier;
    logic sync_pulse, gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl, fault_latched;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm3_leg_scheduler #(.CARRIER_MAX(CMAX), .CARRIER_STEP(STEP), .DEADTIME(DT), .DT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mod_a(mod_a), .mod_b(mod_b), .mod_c(mod_c), .mod_valid(mod_valid),
        .fault(fault), .fault_clr(fault_clr),
        .carrier(carrier), .sync_pulse(sync_pulse),
        .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh),
        .gate_bl(gate_bl), .gate_ch(gate_ch), .gate_cl(gate_cl),
        .fault_latched(fault_latched)
    );

    // Reference model: carrier from an enabled-edge count, gates from cmp sample runs.
    int m_n;
    int m_sh[3];
    int m_act[3];
    bit m_cmp[3];
    bit m_fq;
    int m_last[3];   // 0 none (after reset/fault), 1 high side was last on, 2 low side
    int m_run[3];
    int m_fresh[3];
    bit m_h[3];
    bit m_l[3];

    function automatic int tri_val(input int n);
        int p;
        p = (n * STEP) % (4 * CMAX);
        return (p <= 2 * CMAX) ? (-CMAX + p) : (3 * CMAX - p);
    endfunction

    task automatic leg_step(input int i, input bit f);
        bit c;
        c = m_cmp[i];
        if (f) begin
            m_last[i] = 0; m_fresh[i] = 0; m_run[i] = 0; m_h[i] = 0; m_l[i] = 0;
        end else if (enable) begin
            if (m_last[i] == 0) begin
                m_fresh[i]++;
                if (m_fresh[i] >= DT + 1) begin
                    m_last[i] = c ? 1 : 2; m_h[i] = c; m_l[i] = !c; m_run[i] = 0;
                end
            end else if ((m_last[i] == 1) == c) begin
                m_h[i] = c; m_l[i] = !c; m_run[i] = 0;
            end else begin
                m_run[i]++; m_h[i] = 0; m_l[i] = 0;
                if (m_run[i] >= DT + 1) begin
                    m_last[i] = c ? 1 : 2; m_h[i] = c; m_l[i] = !c; m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic model_step();
        int car;
        bit f;
        bit nc[3];
        car = tri_val(m_n);
        f = fault || m_fq;
        if (reset) begin
            m_n = 0; m_fq = 0;
            for (int i = 0; i < 3; i++) begin
                m_sh[i] = 0; m_act[i] = 0; m_cmp[i] = 0;
                m_last[i] = 0; m_run[i] = 0; m_fresh[i] = 0; m_h[i] = 0; m_l[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 3; i++) leg_step(i, f);
        if (enable) begin
            for (int i = 0; i < 3; i++) nc[i] = (m_act[i] > car);
            if (car == CMAX || car == -CMAX)
                for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
            for (int i = 0; i < 3; i++) m_cmp[i] = nc[i];
            m_n++;
        end
        if (mod_valid) begin
            m_sh[0] = int'(mod_a); m_sh[1] = int'(mod_b); m_sh[2] = int'(mod_c);
        end
        if (fault) m_fq = 1;
        else if (fault_clr) m_fq = 0;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("carrier", carrier, tri_val(m_n));
        chk("sync_pulse", sync_pulse, tri_val(m_n) == -CMAX);
        chk("gates", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl},
            {m_h[0], m_l[0], m_h[1], m_l[1], m_h[2], m_l[2]});
        chk("fault_latched", fault_latched, m_fq);
    endtask

    task automatic wait_car(input int v, input string name);
        int k;
        k = 0;
        while (carrier != v && k < 100) begin
            cyc();
            k++;
        end
        chk(name, carrier == v, 1);
    endtask

    function automatic logic signed [15:0] rnd_mod();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 16'sd32767;
        if (r == 1) return -16'sd32768;
        r = $urandom_range(0, 24);
        return 16'(r - 12);
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if ((gate_ah && gate_al) || (gate_bh && gate_bl) || (gate_ch && gate_cl)) begin
                errors++;
                $display("FAIL overlap at t=%0t: a=%b%b b=%b%b c=%b%b, required no pair both 1",
                         $time, gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl);
            end
        end
    end

    typedef struct {
        int steps;
        int car;
        bit sync;
    } vec_t;
    vec_t vec[8];

    int run, rises, k;
    bit seen, found, ph, pl;
    logic signed [15:0] frozen;

    initial begin
        vec[0] = '{0, -8, 1};
        vec[1] = '{1, -7, 0};
        vec[2] = '{7, 0, 0};
        vec[3] = '{8, 8, 0};
        vec[4] = '{1, 7, 0};
        vec[5] = '{15, -8, 1};
        vec[6] = '{1, -7, 0};
        vec[7] = '{31, -8, 1};

        reset = 1; enable = 0; mod_valid = 0; fault = 0; fault_clr = 0;
        mod_a = 0; mod_b = 0; mod_c = 0;
        cyc();
        cyc();
        chk("rst_carrier", carrier, -8);
        chk("rst_sync", sync_pulse, 1);
        chk("rst_gates", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}, 0);
        chk("rst_fault", fault_latched, 0);

        reset = 0; enable = 1;
        for (int i = 0; i < 8; i++) begin
            repeat (vec[i].steps) cyc();
            chk("vec_carrier", carrier, vec[i].car);
            chk("vec_sync", sync_pulse, vec[i].sync);
        end

        // Dead time on leg A with mod_a = 0.
        run = 0; rises = 0; seen = 0;
        for (int i = 0; i < 128; i++) begin
            ph = gate_ah; pl = gate_al;
            cyc();
            if (!gate_ah && !gate_al) run++;
            else begin
                if ((gate_ah && !ph) || (gate_al && !pl)) begin
                    if (seen) chk("dt_len", run, DT);
                    seen = 1;
                    rises++;
                end
                run = 0;
            end
        end
        chk("dt_rises", rises >= 6, 1);

        // Shadow load mid up-ramp takes effect at the peak.
        wait_car(-8, "wait_valley1");
        repeat (8) cyc();
        chk("mid_ramp", carrier, 0);
        mod_valid = 1; mod_b = 5;
        cyc();
        mod_valid = 0;
        found = 0; k = 0;
        while (!found && k < 80) begin
            pl = gate_bl; cyc(); k++;
            if (pl && !gate_bl) found = 1;
        end
        chk("shadow_found", found, 1);
        chk("shadow_switch_car", carrier, 2);

        // New value on a valley edge waits for the next peak.
        wait_car(-8, "wait_valley2");
        mod_valid = 1; mod_b = -5;
        cyc();
        mod_valid = 0;
        found = 0; k = 0;
        while (!found && k < 80) begin
            ph = gate_bh; cyc(); k++;
            if (ph && !gate_bh) found = 1;
        end
        chk("defer_found", found, 1);
        chk("defer_switch_car", carrier, 7);

        // Fault while a high gate is on.
        k = 0;
        while (!gate_ah && k < 80) begin cyc(); k++; end
        chk("fault_pre_high", gate_ah, 1);
        fault = 1;
        cyc();
        fault = 0;
        chk("fault_gates", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}, 0);
        chk("fault_latch", fault_latched, 1);
        fault = 1; fault_clr = 1;
        cyc();
        chk("fault_clr_ignored", fault_latched, 1);
        fault = 0; fault_clr = 0;
        repeat (3) cyc();
        chk("fault_held", fault_latched, 1);
        chk("fault_held_gates", {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}, 0);
        fault_clr = 1;
        cyc();
        fault_clr = 0;
        chk("fault_cleared", fault_latched, 0);
        run = 0; k = 0;
        while (!(gate_ah || gate_al || gate_bh || gate_bl || gate_ch || gate_cl) && k < 50) begin
            run++; cyc(); k++;
        end
        chk("clear_rise", gate_ah || gate_al || gate_bh || gate_bl || gate_ch || gate_cl, 1);
        chk("clear_dt", run >= DT, 1);

        // Enable low during a dead time freezes the count.
        found = 0; k = 0;
        while (!found && k < 80) begin
            ph = gate_ah; cyc(); k++;
            if (ph && !gate_ah) found = 1;
        end
        chk("dtl_found", found, 1);
        run = 1; frozen = carrier;
        enable = 0;
        repeat (10) begin
            cyc();
            chk("frz_carrier", carrier, frozen);
            chk("frz_gates", {gate_ah, gate_al}, 0);
            if (!gate_ah && !gate_al) run++;
        end
        enable = 1;
        k = 0;
        while (!gate_al && k < 20) begin
            cyc(); k++;
            if (!gate_al && !gate_ah) run++;
        end
        chk("frz_al_rise", gate_al, 1);
        chk("frz_dt", run, DT + 10);

        // Saturated modulation on phase C.
        mod_valid = 1; mod_c = 16'sd32767;
        cyc();
        mod_valid = 0;
        repeat (40) cyc();
        run = 0;
        repeat (64) begin cyc(); if (gate_ch && !gate_cl) run++; end
        chk("sat_hi", run, 64);
        mod_valid = 1; mod_c = -16'sd32768;
        cyc();
        mod_valid = 0;
        repeat (40) cyc();
        run = 0;
        repeat (64) begin cyc(); if (gate_cl && !gate_ch) run++; end
        chk("sat_lo", run, 64);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            mod_valid = ($urandom_range(0, 7) == 0);
            mod_a     = rnd_mod();
            mod_b     = rnd_mod();
            mod_c     = rnd_mod();
            fault     = ($urandom_range(0, 99) == 0);
            fault_clr = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
